ifetch_initiator: RTL and testbench

//  Instruction-fetch initiator for the treq*/trsp* instruction port; the requesting end of the link that boot_rom-style memories respond to.

---
 rtl/ifetch_initiator.sv | 141 ++++++++++++++
 tb/tb_ifetch_initiator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_initiator.sv
// Instruction-fetch initiator: issues sequential word fetches on the treq/trsp link under a
// credit limit, buffers in-order responses and hands {pc, instr, err} to decode.
module ifetch_initiator #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [1:0]  priv,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        treqready,
  output logic        treqvalid,
  output logic [1:0]  treqpriv,
  output logic [31:0] treqaddr,
  output logic        trspready,
  input  logic        trspvalid,
  input  logic        trsprerr,
  input  logic [31:0] trspdata,
  output logic        ivalid,
  input  logic        iready,
  output logic [31:0] ipc,
  output logic [31:0] iinstr,
  output logic        ierr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 2;

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            trspready_q;

  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic            err_mem   [DEPTH];

  logic [SW-1:0]   credit_sum;
  logic            req_hs, rsp_hs, keep, push, pop;
  logic [31:0]     redirect_word;
  logic [1:0]      unused_redirect_lsb;

  assign redirect_word       = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = redirect_pc[1:0];

  // Buffered entries plus every response still owed (kept or stale) must fit the buffer.
  assign credit_sum = SW'(count_q) + SW'(outstanding_q) + SW'(discard_q);

  assign treqvalid = trspready_q && (state_q == StRun) && !redirect_valid &&
                     (credit_sum < SW'(DEPTH));
  assign treqaddr  = fetch_pc_q;
  assign treqpriv  = priv;
  assign trspready = trspready_q;

  assign req_hs = treqvalid && treqready;
  assign rsp_hs = trspvalid && trspready_q;
  assign keep   = rsp_hs && (discard_q == '0) && (state_q == StRun);
  assign push   = keep && !redirect_valid;
  assign pop    = ivalid && iready && !redirect_valid;

  assign ivalid = (count_q != '0);
  assign ipc    = ivalid ? pc_mem[rd_ptr_q]    : 32'h0;
  assign iinstr = ivalid ? instr_mem[rd_ptr_q] : 32'h0;
  assign ierr   = ivalid ? err_mem[rd_ptr_q]   : 1'b0;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_hs);
    count_d       = count_q + CW'(push) - CW'(pop);

    if (req_hs) fetch_pc_d = fetch_pc_q + 32'd4;
    if (rsp_hs && (discard_q != '0)) discard_d = discard_q - CW'(1);
    if (keep) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
      if (trsprerr) state_d = StHalted;
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    // Everything still in flight after this cycle belongs to the abandoned stream.
    if (redirect_valid) begin
      state_d    = StRun;
      fetch_pc_d = redirect_word;
      rsp_pc_d   = redirect_word;
      discard_d  = outstanding_q - CW'(rsp_hs);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_VECTOR;
      rsp_pc_q      <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      trspready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      trspready_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= rsp_pc_q;
      instr_mem[wr_ptr_q] <= trspdata;
      err_mem[wr_ptr_q]   <= trsprerr;
    end
  end

  assert property (@(posedge clk) disable iff (!resetb)
                   !(push && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_ifetch_initiator.sv
// Randomized bench for ifetch_initiator: an in-order echo responder plus a transaction-level
// model of the fetch stream (in-flight queue tagged by redirect generation, decode queue).
module tb_ifetch_initiator;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetb;
  logic [1:0]  priv;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        treqready;
  logic        treqvalid;
  logic [1:0]  treqpriv;
  logic [31:0] treqaddr;
  logic        trspready;
  logic        trspvalid;
  logic        trsprerr;
  logic [31:0] trspdata;
  logic        ivalid;
  logic        iready;
  logic [31:0] ipc;
  logic [31:0] iinstr;
  logic        ierr;

  ifetch_initiator #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .resetb         (resetb),
    .priv           (priv),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .treqready      (treqready),
    .treqvalid      (treqvalid),
    .treqpriv       (treqpriv),
    .treqaddr       (treqaddr),
    .trspready      (trspready),
    .trspvalid      (trspvalid),
    .trsprerr       (trsprerr),
    .trspdata       (trspdata),
    .ivalid         (ivalid),
    .iready         (iready),
    .ipc            (ipc),
    .iinstr         (iinstr),
    .ierr           (ierr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int gen; } req_t;
  typedef struct { logic [31:0] pc; logic err; } ent_t;

  req_t        rsp_q[$];
  ent_t        buf_q[$];
  int          gen, n_checks, n_errors, n_pops, n_err_pops;
  logic        halted, stalled_prev, err_en;
  logic [31:0] exp_req, stalled_addr, err_addr;
  int unsigned rdy_pct, rsp_pct, irdy_pct;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rsp_q.delete();
    buf_q.delete();
    gen++;
    halted       = 1'b0;
    stalled_prev = 1'b0;
    exp_req      = RV;
  endtask

  task automatic check_reset_outputs();
    check("rst_treqvalid", 32'(treqvalid), 32'd0);
    check("rst_trspready", 32'(trspready), 32'd0);
    check("rst_ivalid", 32'(ivalid), 32'd0);
    check("rst_ipc", ipc, 32'd0);
    check("rst_iinstr", iinstr, 32'd0);
    check("rst_ierr", 32'(ierr), 32'd0);
  endtask

  // One clock: drive at negedge, check and advance the model, then wait for the posedge.
  task automatic cycle(input logic redir, input logic [31:0] target);
    req_t r;
    @(negedge clk);
    treqready      = ($urandom_range(99) < rdy_pct);
    iready         = ($urandom_range(99) < irdy_pct);
    priv           = 2'($urandom_range(3));
    redirect_valid = redir;
    redirect_pc    = target;
    if (rsp_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
      trspvalid = 1'b1;
      trspdata  = rsp_q[0].addr;
      trsprerr  = err_en && (rsp_q[0].addr == err_addr);
    end else begin
      trspvalid = 1'b0;
      trspdata  = $urandom;
      trsprerr  = 1'($urandom_range(1));
    end
    #1;
    check("trspready", 32'(trspready), 32'd1);
    check("ivalid", 32'(ivalid), 32'(buf_q.size() != 0));
    check("treqpriv", 32'(treqpriv), 32'(priv));
    if (redir || halted) check("treqvalid_off", 32'(treqvalid), 32'd0);
    if (stalled_prev && !redir && !halted) begin
      check("hold_valid", 32'(treqvalid), 32'd1);
      check("hold_addr", treqaddr, stalled_addr);
    end
    if (treqvalid && treqready) begin
      check("treqaddr", treqaddr, exp_req);
      check("credit", 32'(rsp_q.size() + buf_q.size() < DEPTH), 32'd1);
      rsp_q.push_back('{treqaddr, gen});
      exp_req = exp_req + 32'd4;
    end
    stalled_prev = treqvalid && !treqready;
    stalled_addr = treqaddr;
    if (ivalid && iready && buf_q.size() > 0) begin
      check("ipc", ipc, buf_q[0].pc);
      check("iinstr", iinstr, buf_q[0].pc);
      check("ierr", 32'(ierr), 32'(buf_q[0].err));
      if (ierr) n_err_pops++;
      n_pops++;
      if (!redir) void'(buf_q.pop_front());
    end
    if (trspvalid && trspready && rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      if (r.gen == gen && !halted) begin
        buf_q.push_back('{r.addr, trsprerr});
        if (trsprerr) halted = 1'b1;
      end
    end
    if (redir) begin
      gen++;
      buf_q.delete();
      halted  = 1'b0;
      exp_req = {target[31:2], 2'b00};
    end
    @(posedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
  endtask

  initial begin
    int   pops_before;
    logic reached;
    gen = 0; n_checks = 0; n_errors = 0; n_pops = 0; n_err_pops = 0;
    err_en = 1'b0; err_addr = 32'h8;
    resetb = 1'b0; priv = 2'd0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    treqready = 1'b0; trspvalid = 1'b0; trsprerr = 1'b0; trspdata = 32'h0; iready = 1'b0;
    model_reset();
    #2;
    check_reset_outputs();
    @(negedge clk);
    resetb = 1'b1;
    #1;
    check("rel_trspready", 32'(trspready), 32'd0);
    check("rel_treqvalid", 32'(treqvalid), 32'd0);
    @(posedge clk);

    // Back-to-back streaming from the reset vector.
    rdy_pct = 100; rsp_pct = 100; irdy_pct = 100;
    run(20);
    check("stream_progress", 32'(n_pops > 10), 32'd1);

    // Decode stalled: credit fills the buffer and fetch stops.
    irdy_pct = 0;
    run(12);
    #1;
    check("full_treqvalid", 32'(treqvalid), 32'd0);
    check("full_ivalid", 32'(ivalid), 32'd1);
    check("full_inflight", 32'(rsp_q.size()), 32'd0);
    irdy_pct = 100;
    run(20);

    // Redirect with two requests in flight: their responses must be dropped.
    rsp_pct = 0;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      cycle(1'b0, 32'h0);
      reached = (rsp_q.size() >= 2);
    end
    check("inflight_reached", 32'(reached), 32'd1);
    rdy_pct = 0;
    cycle(1'b1, 32'h100);
    rdy_pct = 100; rsp_pct = 100;
    run(20);

    // Bus error at 0x8 halts fetch until the next redirect.
    err_en = 1'b1;
    cycle(1'b1, 32'h0);
    run(20);
    check("err_seen", 32'(n_err_pops), 32'd1);
    check("err_halted", 32'(halted), 32'd1);
    err_en = 1'b0;
    pops_before = n_pops;
    cycle(1'b1, 32'h0);
    run(20);
    check("err_resume", 32'(n_pops > pops_before), 32'd1);

    // Random back-pressure, latency and redirects, including the wrap-around target.
    rdy_pct = 50; rsp_pct = 60; irdy_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0)
        cycle(1'b1, ($urandom_range(3) == 0) ? 32'hFFFF_FFFC | 32'($urandom_range(3))
                                             : $urandom);
      else
        cycle(1'b0, 32'h0);
    end
    rdy_pct = 100; rsp_pct = 100; irdy_pct = 100;
    cycle(1'b1, 32'hFFFF_FFFE);
    run(30);

    // Asynchronous reset mid-stream with requests outstanding.
    rsp_pct = 0;
    run(3);
    @(negedge clk);
    resetb = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    trspvalid = 1'b0;
    #20;
    @(negedge clk);
    resetb = 1'b1;
    #1;
    check("rel2_trspready", 32'(trspready), 32'd0);
    @(posedge clk);
    rsp_pct = 100;
    pops_before = n_pops;
    run(20);
    check("post_reset_progress", 32'(n_pops > pops_before), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
